// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder for the execute unit's data-memory port. Decodes a 12-bit byte
//   address into a 3840x8 RAM (0x000-0xEFF) and an IO window (0xF00-0xFFF).
//   The IO window holds a TX byte FIFO, an RX holding register and sticky error flags.
//     0xF00 TX_DATA   W: push, R: 0x00
//     0xF01 STATUS    R: {3'b0, prot_err, tx_drop, rx_full, tx_empty, tx_full}
//                     W: 1 to bit3/bit4 clears tx_drop/prot_err
//     0xF02 RX_DATA   R: rx_hold, pops (clears rx_full)
//     0xF03 TX_COUNT  R: FIFO occupancy
//     0xF04-0xFFF     read 0x00, writes ignored
//   Optional macro DMEM_WR_PROTECT_EN: RAM writes in [PROT_LO, PROT_HI] are
//   suppressed and set prot_err. Without it prot_err is constant 0.
// Ports
//   clk, reset             clock, synchronous active-high reset
//   d_mem_en/rd/wr         access strobe and request type (wr wins over rd)
//   d_mem_addr, d_mem_wdata  byte address, store data
//   d_mem_rdata            combinational load data, 0x00 when not reading
//   io_tx_data/vld/rdy     TX byte stream out (head of FIFO, registered)
//   io_rx_data/vld/rdy     RX byte stream in (rdy = !rx_full)
//   err_irq                registered OR of the sticky flags
module data_mem_responder #(
   parameter int TX_DEPTH = 8
`ifdef DMEM_WR_PROTECT_EN
   ,
   parameter logic [11:0] PROT_LO = 12'h000,
   parameter logic [11:0] PROT_HI = 12'h0FF
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_mem_en,
   input  logic        d_mem_rd,
   input  logic        d_mem_wr,
   input  logic [11:0] d_mem_addr,
   input  logic [7:0]  d_mem_wdata,
   output logic [7:0]  d_mem_rdata,
   output logic [7:0]  io_tx_data,
   output logic        io_tx_vld,
   input  logic        io_tx_rdy,
   input  logic [7:0]  io_rx_data,
   input  logic        io_rx_vld,
   output logic        io_rx_rdy,
   output logic        err_irq
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    ram [0:3839];
   logic [7:0]    tx_mem [0:TX_DEPTH-1];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
   logic [CW-1:0] tx_count, cnt_nxt;
   logic [7:0]    head_nxt;
   logic [7:0]    rx_hold;
   logic          rx_full, tx_drop, prot_err;

   logic wr_cyc, rd_cyc, is_ram, prot_hit, ram_we;
   logic tx_push, tx_pop, tx_acc, rx_pop, rx_cap, stat_wr;
   logic [7:0] status;

   assign wr_cyc  = d_mem_en & d_mem_wr;
   // A cycle with both rd and wr is a write: no read side effects.
   assign rd_cyc  = d_mem_en & d_mem_rd & ~d_mem_wr;
   assign is_ram  = d_mem_addr < 12'hF00;

   assign tx_push = wr_cyc && (d_mem_addr == 12'hF00);
   assign tx_pop  = io_tx_vld & io_tx_rdy;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign tx_acc  = tx_push && ((tx_count < CW'(TX_DEPTH)) || tx_pop);
   assign stat_wr = wr_cyc && (d_mem_addr == 12'hF01);
   assign rx_pop  = rd_cyc && (d_mem_addr == 12'hF02);
   assign rx_cap  = io_rx_vld & ~rx_full;

`ifdef DMEM_WR_PROTECT_EN
   assign prot_hit = wr_cyc && is_ram && (d_mem_addr >= PROT_LO) && (d_mem_addr <= PROT_HI);
`else
   assign prot_hit = 1'b0;
   assign prot_err = 1'b0;
`endif
   assign ram_we = wr_cyc && is_ram && !prot_hit;

   assign io_tx_vld  = (tx_count != '0);
   assign io_rx_rdy  = ~rx_full;
   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign status     = {3'b000, prot_err, tx_drop, rx_full, (tx_count == '0),
                        (tx_count == CW'(TX_DEPTH))};

   always_ff @(posedge clk) begin
      if (ram_we) ram[d_mem_addr] <= d_mem_wdata;
      if (tx_acc) tx_mem[wr_ptr] <= d_mem_wdata;
   end

   // io_tx_data is a register, so work out what the head will be after this edge.
   always_comb begin
      cnt_nxt = tx_count;
      if (tx_acc && !tx_pop)      cnt_nxt = tx_count + 1'b1;
      else if (!tx_acc && tx_pop) cnt_nxt = tx_count - 1'b1;
      head_nxt = io_tx_data;
      if (cnt_nxt == '0)
         head_nxt = 8'h00;
      else if (tx_pop)
         // Only one entry was queued: the new head is the byte pushed now.
         head_nxt = (tx_count > CW'(1)) ? tx_mem[rd_ptr_inc] : d_mem_wdata;
      else if (tx_count == '0)
         head_nxt = d_mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         tx_count   <= '0;
         io_tx_data <= 8'h00;
         rx_full    <= 1'b0;
         rx_hold    <= 8'h00;
         tx_drop    <= 1'b0;
         err_irq    <= 1'b0;
      end else begin
         if (tx_acc) wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop) rd_ptr <= rd_ptr_inc;
         tx_count   <= cnt_nxt;
         io_tx_data <= head_nxt;
         if (rx_pop) rx_full <= 1'b0;
         if (rx_cap) begin
            rx_full <= 1'b1;
            rx_hold <= io_rx_data;
         end
         // Set wins over a same-cycle clear.
         tx_drop <= (tx_drop & ~(stat_wr & d_mem_wdata[3])) | (tx_push & ~tx_acc);
         // Follows the flags by one cycle.
         err_irq <= tx_drop | prot_err;
      end
   end

`ifdef DMEM_WR_PROTECT_EN
   always_ff @(posedge clk) begin
      if (reset) prot_err <= 1'b0;
      else       prot_err <= (prot_err & ~(stat_wr & d_mem_wdata[4])) | prot_hit;
   end
`endif

   always_comb begin
      d_mem_rdata = 8'h00;
      if (d_mem_en & d_mem_rd) begin
         if (is_ram) d_mem_rdata = ram[d_mem_addr];
         else begin
            case (d_mem_addr)
               12'hF01: d_mem_rdata = status;
               12'hF02: d_mem_rdata = rx_hold;
               12'hF03: d_mem_rdata = 8'(tx_count);
               default: d_mem_rdata = 8'h00;
            endcase
         end
      end
   end

endmodule
